// File: rtl/if_fetch_pkg.sv
// Shared constants, types and state encoding for the instruction-fetch stage.
// Imported by the fetch bus interface and the fetch stage itself.
package if_fetch_pkg;

    localparam logic        RstEnable = 1'b1;
    localparam logic        Stop      = 1'b1;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;

    typedef enum logic [1:0] {
        IF_REQ     = 2'd0,
        IF_HOLD    = 2'd1,
        IF_DISCARD = 2'd2
    } if_state_e;

    // Sequential successor of a word-aligned pc; wraps modulo 2^32.
    function automatic inst_addr_t pc_inc(input inst_addr_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/ack bus between the fetch stage (master) and memory (slave).
// inst_ack is a one-cycle completion pulse and may arrive in the same cycle as inst_req.
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic       inst_req;
    inst_addr_t inst_addr;
    logic       inst_ack;
    inst_t      inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_ack,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_ack,
        output inst_rdata
    );

endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the pc, issues word fetches, presents pc/inst to IF/ID,
// and handles stalls, delayed-branch redirects and exception flushes.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter inst_addr_t RESET_PC = 32'h8000_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] stall,
    input  logic       flush,
    input  inst_addr_t new_pc,
    input  logic       branch_flag_i,
    input  inst_addr_t branch_target_address_i,
    if_fetch_if.master imem,
    output inst_addr_t if_pc,
    output inst_t      if_inst,
    output logic       stallreq_if
);

    if_state_e  r_state;
    inst_addr_t r_pc;
    inst_addr_t r_disc_addr;
    logic       r_br_pend;
    inst_addr_t r_br_tgt;
    inst_t      r_inst_buf;

    logic       w_ack;
    logic       w_stop;
    logic       w_adv;
    inst_addr_t w_next_pc;
    logic       w_unused_stall;

    assign w_ack          = imem.inst_ack;
    assign w_stop         = (stall[0] == Stop);
    assign w_unused_stall = ^stall[5:1];

    // An incoming branch overrides an older captured one.
    always_comb begin
        if (branch_flag_i) begin
            w_next_pc = branch_target_address_i;
        end else if (r_br_pend) begin
            w_next_pc = r_br_tgt;
        end else begin
            w_next_pc = pc_inc(r_pc);
        end
    end

    assign w_adv = !flush && !w_stop &&
                   ((r_state == IF_REQ && w_ack) || r_state == IF_HOLD);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state     <= IF_REQ;
            r_pc        <= RESET_PC;
            r_disc_addr <= ZeroWord;
            r_br_pend   <= 1'b0;
            r_br_tgt    <= ZeroWord;
            r_inst_buf  <= ZeroWord;
        end else if (flush) begin
            r_pc      <= new_pc;
            r_br_pend <= 1'b0;
            case (r_state)
                IF_REQ: begin
                    // The in-flight fetch cannot be aborted; remember its address.
                    if (!w_ack) begin
                        r_state     <= IF_DISCARD;
                        r_disc_addr <= r_pc;
                    end
                end
                IF_HOLD:    r_state <= IF_REQ;
                IF_DISCARD: if (w_ack) r_state <= IF_REQ;
                default:    r_state <= IF_REQ;
            endcase
        end else begin
            if (w_adv) begin
                r_pc      <= w_next_pc;
                r_br_pend <= 1'b0;
            end else if (branch_flag_i) begin
                // Keep the branch alive while IF waits on its delay slot.
                r_br_pend <= 1'b1;
                r_br_tgt  <= branch_target_address_i;
            end
            case (r_state)
                IF_REQ: begin
                    if (w_ack && w_stop) begin
                        r_inst_buf <= imem.inst_rdata;
                        r_state    <= IF_HOLD;
                    end
                end
                IF_HOLD:    if (!w_stop) r_state <= IF_REQ;
                IF_DISCARD: if (w_ack) r_state <= IF_REQ;
                default:    r_state <= IF_REQ;
            endcase
        end
    end

    always_comb begin
        imem.inst_req  = 1'b0;
        imem.inst_addr = ZeroWord;
        if_pc          = ZeroWord;
        if_inst        = ZeroWord;
        stallreq_if    = 1'b0;
        if (rst != RstEnable) begin
            unique case (r_state)
                IF_REQ: begin
                    imem.inst_req  = 1'b1;
                    imem.inst_addr = r_pc;
                    if (w_ack) begin
                        if (!flush) begin
                            if_pc   = r_pc;
                            if_inst = imem.inst_rdata;
                        end
                    end else begin
                        stallreq_if = 1'b1;
                    end
                end
                IF_HOLD: begin
                    if (!flush) begin
                        if_pc   = r_pc;
                        if_inst = r_inst_buf;
                    end
                end
                IF_DISCARD: begin
                    imem.inst_req  = 1'b1;
                    imem.inst_addr = r_disc_addr;
                    stallreq_if    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios then random traffic, all checked against a
// flag-based reference model of the fetch rules.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_if bus ();

    if_fetch #(
        .RESET_PC (32'h8000_0000)
    ) u_dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .imem                    (bus.master),
        .if_pc                   (if_pc),
        .if_inst                 (if_inst),
        .stallreq_if             (stallreq_if)
    );

    always #5 clk = ~clk;

    // Reference model: pc, a held word, an orphaned fetch to drop, a captured branch.
    logic [31:0] m_pc;
    logic        m_held;
    logic [31:0] m_word;
    logic        m_drop;
    logic [31:0] m_drop_addr;
    logic        m_bp;
    logic [31:0] m_bt;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic a = 1'b0, input logic [31:0] rd = 32'h0,
                        input logic s0 = 1'b0, input logic fl = 1'b0,
                        input logic [31:0] npc = 32'h0, input logic b = 1'b0,
                        input logic [31:0] bt = 32'h0, input logic r = 1'b0,
                        input logic [4:0] shi = 5'h0);
        logic        ack;
        logic        was_req;
        logic        adv;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_stl;
        @(negedge clk);
        ack = a && (r || !m_held);
        rst = r;
        stall = {shi, s0};
        flush = fl;
        new_pc = npc;
        branch_flag_i = b;
        branch_target_address_i = bt;
        bus.inst_ack = ack;
        bus.inst_rdata = rd;
        #2;
        was_req = !m_held && !m_drop;
        e_req = 1'b0; e_addr = 32'h0; e_pc = 32'h0; e_inst = 32'h0; e_stl = 1'b0;
        if (!r) begin
            if (m_held) begin
                if (!fl) begin e_pc = m_pc; e_inst = m_word; end
            end else if (m_drop) begin
                e_req = 1'b1; e_addr = m_drop_addr; e_stl = 1'b1;
            end else begin
                e_req = 1'b1; e_addr = m_pc;
                if (!ack) e_stl = 1'b1;
                else if (!fl) begin e_pc = m_pc; e_inst = rd; end
            end
        end
        chk1("inst_req", bus.inst_req, e_req);
        if (e_req) chk32("inst_addr", bus.inst_addr, e_addr);
        chk32("if_pc", if_pc, e_pc);
        chk32("if_inst", if_inst, e_inst);
        chk1("stallreq_if", stallreq_if, e_stl);
        if (r) begin
            m_pc = 32'h8000_0000; m_held = 1'b0; m_drop = 1'b0; m_bp = 1'b0;
        end else if (fl) begin
            if (was_req && !ack) begin m_drop = 1'b1; m_drop_addr = m_pc; end
            else if (m_drop && ack) m_drop = 1'b0;
            m_held = 1'b0; m_pc = npc; m_bp = 1'b0;
        end else begin
            adv = (m_held && !s0) || (was_req && ack && !s0);
            if (was_req && ack && s0) begin m_held = 1'b1; m_word = rd; end
            else if (m_held && !s0) m_held = 1'b0;
            if (m_drop && ack) m_drop = 1'b0;
            if (adv) begin
                m_pc = b ? bt : (m_bp ? m_bt : m_pc + 32'd4);
                m_bp = 1'b0;
            end else if (b) begin
                m_bp = 1'b1; m_bt = bt;
            end
        end
    endtask

    initial begin
        logic        ra;
        logic        rs;
        logic        rf;
        logic        rb;
        logic        rr;
        rst = 1'b1; stall = 6'h0; flush = 1'b0; new_pc = 32'h0;
        branch_flag_i = 1'b0; branch_target_address_i = 32'h0;
        bus.inst_ack = 1'b0; bus.inst_rdata = 32'h0;
        m_pc = 32'h8000_0000; m_held = 1'b0; m_word = 32'h0; m_drop = 1'b0;
        m_drop_addr = 32'h0; m_bp = 1'b0; m_bt = 32'h0;

        // Reset cycle, with a stray ack that must be ignored.
        step(.a(1'b1), .rd(32'h1111_1111), .r(1'b1));
        chk1("rst_req", bus.inst_req, 1'b0);

        // Zero-wait fetches.
        for (int k = 0; k < 4; k++) begin
            step(.a(1'b1), .rd(32'h0100_0000 + k));
            chk32("zw_addr", bus.inst_addr, 32'h8000_0000 + 32'(k) * 32'd4);
            chk1("zw_stallreq", stallreq_if, 1'b0);
        end

        // Ack three cycles late at 0x80000010.
        repeat (3) begin
            step();
            chk1("wait_stallreq", stallreq_if, 1'b1);
            chk32("wait_addr", bus.inst_addr, 32'h8000_0010);
        end
        step(.a(1'b1), .rd(32'h1234_5678));
        chk32("late_inst", if_inst, 32'h1234_5678);
        chk32("late_pc", if_pc, 32'h8000_0010);

        // Ack under stall, then hold, then release.
        step(.a(1'b1), .rd(32'hAABB_CCDD), .s0(1'b1));
        step(.s0(1'b1));
        chk1("hold_req", bus.inst_req, 1'b0);
        chk32("hold_inst", if_inst, 32'hAABB_CCDD);
        step();
        step(.a(1'b1), .rd(32'h2222_2222));
        chk32("post_hold_addr", bus.inst_addr, 32'h8000_0018);

        // Branch raised while the delay slot at 0x8000001C waits.
        step(.b(1'b1), .bt(32'h8000_0100));
        step();
        step(.a(1'b1), .rd(32'h3333_3333));
        step();
        chk32("branch_addr", bus.inst_addr, 32'h8000_0100);

        // Flush (with a competing branch) while waiting; old fetch is dropped.
        step(.fl(1'b1), .npc(32'h8000_0380), .b(1'b1), .bt(32'h8000_0200));
        step();
        chk32("disc_addr", bus.inst_addr, 32'h8000_0100);
        step(.a(1'b1), .rd(32'hDEAD_BEEF));
        chk32("disc_inst", if_inst, 32'h0);
        step(.a(1'b1), .rd(32'h4444_4444));
        chk32("flush_addr", bus.inst_addr, 32'h8000_0380);
        step();
        chk32("flush_next", bus.inst_addr, 32'h8000_0384);

        // Flush coinciding with ack; then pc wrap; then reset mid-wait.
        step(.a(1'b1), .rd(32'h5555_5555), .fl(1'b1), .npc(32'hFFFF_FFFC));
        chk32("flush_ack_inst", if_inst, 32'h0);
        step(.a(1'b1), .rd(32'h6666_6666));
        chk32("wrap_pre", bus.inst_addr, 32'hFFFF_FFFC);
        step();
        chk32("wrap_addr", bus.inst_addr, 32'h0000_0000);
        step();
        step(.r(1'b1));
        step();
        chk32("rst_mid_addr", bus.inst_addr, 32'h8000_0000);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rr = ($urandom_range(0, 99) == 0);
            rs = ($urandom_range(0, 3) == 0);
            rf = ($urandom_range(0, 15) == 0);
            rb = ($urandom_range(0, 7) == 0);
            ra = ($urandom_range(0, 1) == 1);
            if (rf && m_drop && ra) ra = 1'b0;
            step(.a(ra), .rd($urandom), .s0(rs), .fl(rf), .npc($urandom & 32'hFFFF_FFFC),
                 .b(rb), .bt($urandom & 32'hFFFF_FFFC), .r(rr), .shi(5'($urandom)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage that owns the program counter. It issues word fetches on the instruction-memory request/ack bus and presents the fetched pc/instruction pair to the IF/ID pipeline register. It handles pipeline stalls, delayed-branch redirects from ID, and exception flushes. While a fetch is outstanding it raises a stall request toward the pipeline controller, so IF/ID inserts a bubble.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset; the first fetch address.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset; synchronous, active-high
stall  in  6  pipeline stall vector; bit 0 = hold PC/IF stage (`Stop=1)
flush  in  1  exception flush; redirect to new_pc
new_pc  in  32  exception/ERET target, sampled when flush=1
branch_flag_i  in  1  branch taken, from ID (delay-slot semantics)
branch_target_address_i  in  32  branch target, from ID
inst_req  out  1  fetch request
inst_addr  out  32  fetch address
inst_ack  in  1  one-cycle completion pulse; may arrive in the same cycle as inst_req
inst_rdata  in  32  instruction word, valid when inst_ack=1
if_pc  out  32  pc of the presented instruction
if_inst  out  32  presented instruction; ZeroWord (NOP) when none
stallreq_if  out  1  stall request to ctrl while a fetch is pending

Behaviour:
- Reset (rst=1 at edge):
  - pc<=RESET_PC, state<=REQ, br_pend<=0, inst_buf<=0.
  - Outputs in the reset cycle: inst_req=0, inst_addr=0, if_pc=0, if_inst=0, stallreq_if=0.
- States: REQ, HOLD, DISCARD.
- REQ:
  - inst_req=1, inst_addr=pc.
  - Without ack: if_inst=0, if_pc=0, stallreq_if=1.
  - With ack: if_pc=pc, if_inst=inst_rdata (combinational path), stallreq_if=0.
    - If stall[0]=0: pc<=next_pc, stay in REQ.
    - If stall[0]=1: inst_buf<=inst_rdata, go to HOLD.
- HOLD:
  - inst_req=0, if_pc=pc, if_inst=inst_buf, stallreq_if=0.
  - When stall[0]=0: pc<=next_pc, go to REQ.
- DISCARD:
  - inst_req=1, inst_addr=old pc, held stable; if_inst=0, stallreq_if=1.
  - On ack: drop the data, go to REQ. pc already holds the flush target.
- Bus rule: once inst_req is raised, inst_req and inst_addr stay stable until inst_ack. Fetches are never aborted.
- next_pc:
  - If a branch is pending (br_pend=1, or branch_flag_i=1 this cycle): the stored/incoming target, and br_pend is cleared.
  - Otherwise pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - Incoming branch_flag_i takes precedence over an older br_pend.
- Branch capture:
  - If branch_flag_i=1 in a cycle where pc does not advance, then br_pend<=1 and br_tgt<=branch_target_address_i.
  - This keeps the branch alive after ID moves on while IF waits. The delay slot is the instruction being fetched/held.
- Flush has top priority over stall, ack and branch. br_pend<=0 and pc<=new_pc. Then:
  - REQ without ack -> DISCARD.
  - REQ with ack -> REQ; data dropped, if_inst=0 that cycle.
  - HOLD -> REQ; buffer invalidated, if_inst=0.
  - DISCARD -> stays DISCARD, pc updated to new_pc.
- Flush and stall[0] in the same cycle: flush wins; pc still loads new_pc.
- Reset mid-fetch: returns to REQ@RESET_PC. Any ack arriving in the reset cycle is ignored.

Decomposition:
- define.v supplies RstEnable, Stop/NoStop, ZeroWord, InstAddrBus, InstBus.
- Add a state encoding IfStateBus (2 bits) and IF_REQ/IF_HOLD/IF_DISCARD to define.v.
- No sub-module; a single always block plus combinational output logic.

Test Plan:
- Zero-wait ack every cycle, no stalls -> inst_addr 0x80000000, 0x80000004, 0x80000008 on consecutive cycles; stallreq_if never high.
- ack 3 cycles after req at pc 0x80000010 -> stallreq_if=1 for 3 cycles, if_inst=0; inst_addr stable; on ack, if_inst=rdata, if_pc=0x80000010.
- ack with stall[0]=1 for 2 cycles -> HOLD; if_inst=buffered word, no new req; the cycle after the stall drops, req@pc+4.
- branch_flag_i=1 (target 0x80000100) while the delay-slot fetch waits 2 cycles for ack -> the next request after the delay slot is 0x80000100, not pc+4.
- flush (new_pc 0x80000380) while REQ is waiting -> old addr held until ack, data dropped; next req@0x80000380 with br_pend cleared.
- pc=0xFFFFFFFC, ack with no stall -> next inst_addr=0x00000000; rst asserted mid-wait -> next req@0x80000000.
